// File: rtl/tribus_pkg.sv
// tribus_pkg: shared state encoding, bus constants and bank one-hot helper for the tribus arbiter
package tribus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int AW_DEF = 7;
  localparam int DW_DEF = 8;
  localparam int NREQ = 4;
  localparam int NBANK = 4;
  function automatic logic [NBANK-1:0] onehot4(input logic [1:0] b);
    return NBANK'(1) << b;
  endfunction
endpackage

// File: rtl/tribus4_arbiter_if.sv
// tribus4_arbiter_if: requester fields, ACK/RDATA/BUSY and RAM bus; slave = arbiter side, master = requesters+RAM side
interface tribus4_arbiter_if
  import tribus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic [NREQ-1:0] REQ, WE, ACK;
  logic [2*NREQ-1:0] BANK;
  logic [NREQ*AW-1:0] ADDR;
  logic [NREQ*DW-1:0] WDATA;
  logic [DW-1:0] RDATA, RAM_D, RAM_Q;
  logic BUSY;
  logic [AW-1:0] RAM_A;
  logic [NBANK-1:0] RAM_WREN;
  logic [1:0] RAM_ENA;
  modport slave(input REQ, WE, BANK, ADDR, WDATA, RAM_Q, output ACK, RDATA, BUSY, RAM_A, RAM_D, RAM_WREN, RAM_ENA);
  modport master(output REQ, WE, BANK, ADDR, WDATA, RAM_Q, input ACK, RDATA, BUSY, RAM_A, RAM_D, RAM_WREN, RAM_ENA);
endinterface

// File: rtl/tribus4_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker (req, ptr -> valid, first set req at or after ptr)
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] winner
);
  logic [7:0] dbl;
  logic [1:0] off;
  assign dbl = {req, req} >> ptr;
  assign off = dbl[0] ? 2'd0 : dbl[1] ? 2'd1 : dbl[2] ? 2'd2 : 2'd3;
  assign valid = |req;
  assign winner = ptr + off;
endmodule

// File: rtl/tribus4_arbiter.sv
// tribus4_arbiter: round-robin arbiter serialising 4 requesters onto a 4-bank RAM bus (CLK, RSTN, bus.slave)
module tribus4_arbiter
  import tribus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int RD_LAT = 1
) (
  input logic CLK,
  input logic RSTN,
  tribus4_arbiter_if.slave bus
);
  state_t state, state_n;
  logic valid, we_q;
  logic [1:0] pw, ptr, win, ena_q, cnt;
  logic [AW-1:0] a_q;
  logic [DW-1:0] d_q, rdata_q;
  rr_pick4 u_pick (.req(bus.REQ), .ptr(ptr), .valid(valid), .winner(pw));
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      we_q <= 1'b0;
      ena_q <= '0;
      a_q <= '0;
      d_q <= '0;
      rdata_q <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && valid) begin
        win <= pw;
        ptr <= pw + 2'd1;
        we_q <= bus.WE[pw];
        ena_q <= bus.BANK[{pw, 1'b0} +: 2];
        a_q <= bus.ADDR[AW*int'(pw) +: AW];
        d_q <= bus.WDATA[DW*int'(pw) +: DW];
      end
      if (state == ISSUE) cnt <= 2'(RD_LAT);
      if (state == WAIT) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd1) rdata_q <= bus.RAM_Q;
      end
    end
  end
  always_comb begin
    state_n = state == IDLE ? (valid ? ISSUE : IDLE) : state == ISSUE ? (we_q ? RESP : WAIT) : state == WAIT ? (cnt == 2'd1 ? RESP : WAIT) : IDLE;
    bus.RAM_WREN = (state == ISSUE && we_q) ? onehot4(ena_q) : '0;
    bus.ACK = state == RESP ? onehot4(win) : '0;
    bus.BUSY = state != IDLE;
  end
  assign bus.RAM_A = a_q;
  assign bus.RAM_D = d_q;
  assign bus.RAM_ENA = ena_q;
  assign bus.RDATA = rdata_q;
endmodule
